// File: rtl/vga_pkg.sv
// Shared types for the VGA framebuffer write path.
//   CW_DEFAULT  : default coordinate width (matches vga X/Y)
//   pix_t       : 3-bit RGB pixel
//   coord_t     : screen coordinate at the default width
//   arb_state_t : write-arbiter sequencer states
package vga_pkg;
  localparam int CW_DEFAULT = 10;

  typedef logic [2:0]            pix_t;
  typedef logic [CW_DEFAULT-1:0] coord_t;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} arb_state_t;
endpackage

// File: rtl/vga_fb_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index (must be < N)
//   en      : grant enable; no grant when low
//   gnt     : one-hot grant
//   gnt_idx : index of the granted requester (0 when nothing granted)
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   j;

  // Walk the N positions starting at ptr, wrapping; first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !found && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Framebuffer write-port arbiter: shares the single vga write port between
// NUM_REQ pixel writers and a clear sequencer that fills the active area.
//   clk, srst         : clock, async active-high reset
//   width, height     : active area in pixels
//   no_tear, visible  : stall all writes while no_tear & visible
//   clear_start       : one-cycle pulse starting a clear with clear_color
//   clear_busy        : high while a clear is in progress
//   req_valid/x/y/pixel, req_ready : per-requester valid/ready write ports
//   X, Y, pixel, wr_en: registered write to vga
//   drop_cnt          : saturating count of out-of-range writes dropped
module vga_fb_write_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CW      = CW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [CW-1:0]         width,
  input  logic [CW-1:0]         height,
  input  logic                  no_tear,
  input  logic                  visible,
  input  logic                  clear_start,
  input  logic [2:0]            clear_color,
  output logic                  clear_busy,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*CW-1:0] req_x,
  input  logic [NUM_REQ*CW-1:0] req_y,
  input  logic [NUM_REQ*3-1:0]  req_pixel,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [CW-1:0]         X,
  output logic [CW-1:0]         Y,
  output logic [2:0]            pixel,
  output logic                  wr_en,
  output logic [7:0]            drop_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic                 stall, arb_en, in_range;
  logic [CW-1:0]        cx, cy, cw, ch, cw_m1, ch_m1;
  pix_t                 col;
  logic [CW-1:0]        rx [NUM_REQ];
  logic [CW-1:0]        ry [NUM_REQ];
  pix_t                 rp [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rx[i] = req_x[i*CW +: CW];
    assign ry[i] = req_y[i*CW +: CW];
    assign rp[i] = req_pixel[i*3 +: 3];
  end

  assign stall  = no_tear & visible;
  // clear_start wins over any request presented in the same cycle.
  assign arb_en = (state == IDLE) & ~stall & ~clear_start;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign in_range  = (rx[gnt_idx] < width) && (ry[gnt_idx] < height);
  assign cw_m1     = cw - CW'(1);
  assign ch_m1     = ch - CW'(1);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (clear_start)
              state_nxt = (width == '0 || height == '0) ? DONE : CLEAR;
      CLEAR: if (!stall && cx == cw_m1 && cy == ch_m1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // clear_busy is registered: it rises the cycle after clear_start and is
  // still high in DONE, so it covers the cycle the final fill pixel is on
  // the write port.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      X          <= '0;
      Y          <= '0;
      pixel      <= '0;
      wr_en      <= 1'b0;
      clear_busy <= 1'b0;
      drop_cnt   <= '0;
      rr_ptr     <= '0;
      cx         <= '0;
      cy         <= '0;
      cw         <= '0;
      ch         <= '0;
      col        <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            cw         <= width;
            ch         <= height;
            col        <= clear_color;
            cx         <= '0;
            cy         <= '0;
            clear_busy <= 1'b1;
          end else if (|gnt) begin
            rr_ptr <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);
            if (in_range) begin
              wr_en <= 1'b1;
              X     <= rx[gnt_idx];
              Y     <= ry[gnt_idx];
              pixel <= rp[gnt_idx];
            end else if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
        end
        CLEAR: begin
          if (!stall) begin
            wr_en <= 1'b1;
            X     <= cx;
            Y     <= cy;
            pixel <= col;
            if (cx == cw_m1) begin
              cx <= '0;
              cy <= cy + CW'(1);
            end else begin
              cx <= cx + CW'(1);
            end
          end
        end
        DONE:    clear_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
module tb_vga_fb_write_arbiter;
  localparam int NR = 3;
  localparam int CW = 10;

  logic             clk = 1'b0;
  logic             srst;
  logic [CW-1:0]    width, height;
  logic             no_tear, visible, clear_start;
  logic [2:0]       clear_color;
  logic             clear_busy;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*CW-1:0] req_x, req_y;
  logic [NR*3-1:0]  req_pixel;
  logic [CW-1:0]    X, Y;
  logic [2:0]       pixel;
  logic             wr_en;
  logic [7:0]       drop_cnt;

  vga_fb_write_arbiter #(.NUM_REQ(NR), .CW(CW)) dut (
    .clk(clk), .srst(srst), .width(width), .height(height),
    .no_tear(no_tear), .visible(visible), .clear_start(clear_start),
    .clear_color(clear_color), .clear_busy(clear_busy),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_pixel(req_pixel), .req_ready(req_ready),
    .X(X), .Y(Y), .pixel(pixel), .wr_en(wr_en), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side pending transactions
  logic          pv [NR];
  logic [CW-1:0] px [NR];
  logic [CW-1:0] py [NR];
  logic [2:0]    pp [NR];

  typedef struct {
    logic [2:0] v;
    logic       nt;
    logic       vis;
    logic [2:0] rdy;
    logic       wr;
    int         x;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = pv[i];
      req_x[i*CW +: CW]     = px[i];
      req_y[i*CW +: CW]     = py[i];
      req_pixel[i*3 +: 3]   = pp[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    clear_start = 1'b0; no_tear = 1'b0; visible = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pv[i] = 1'b0; px[i] = '0; py[i] = '0; pp[i] = '0;
    end
    drive();
    tick();
    tick();
    srst = 1'b0;
  endtask

  // Runs a clear and checks every fill write against raster order.
  task automatic run_clear(input int w, input int h, input int c,
                           input bit tog, input int abort_at);
    int nw;
    int busy_cyc;
    bit vis_last;
    nw = 0; busy_cyc = 0; vis_last = 1'b0;
    width = CW'(w); height = CW'(h); clear_color = 3'(c);
    no_tear = tog; visible = 1'b0;
    pv[0] = 1'b1; px[0] = CW'(1); py[0] = CW'(1); pp[0] = 3'd1;
    pv[1] = 1'b0; pv[2] = 1'b0;
    drive();
    clear_start = 1'b1;
    #1 chk("clr_start_prio", int'(req_ready), 0);
    tick();
    clear_start = 1'b0;
    width = CW'(w + 3); height = CW'(h + 2); clear_color = ~3'(c);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (clear_busy) busy_cyc++;
      if (wr_en) begin
        chk("clr_x", int'(X), (w > 0) ? nw % w : -1);
        chk("clr_y", int'(Y), (w > 0) ? nw / w : -1);
        chk("clr_pix", int'(pixel), c);
        if (tog) chk("clr_wr_while_visible", int'(vis_last), 0);
        nw++;
        if (abort_at > 0 && nw == abort_at) begin
          #2 srst = 1'b1;
          #1 chk("abort_wr_en", int'(wr_en), 0);
          chk("abort_busy", int'(clear_busy), 0);
          tick();
          srst = 1'b0;
          break;
        end
      end
      if (!clear_busy) break;
      visible  = tog && ((cyc / 4) % 2 == 0);
      vis_last = visible;
      #1 chk("clr_no_ready", int'(req_ready), 0);
      tick();
    end
    pv[0] = 1'b0; drive();
    visible = 1'b0; no_tear = 1'b0;
    width = CW'(640); height = CW'(480);
    if (abort_at == 0) begin
      chk("clr_count", nw, w * h);
      chk("clr_busy_end", int'(clear_busy), 0);
      if (!tog && w * h > 0) chk("clr_busy_cycles", busy_cyc, w * h + 1);
    end
  endtask

  initial begin
    int ptr, dc, g, best, d;
    bit inr;

    width = CW'(640); height = CW'(480); clear_color = 3'd0;
    req_valid = '0; req_x = '0; req_y = '0; req_pixel = '0;
    do_reset();

    // Reset state
    chk("rst_X", int'(X), 0);
    chk("rst_Y", int'(Y), 0);
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(clear_busy), 0);
    chk("rst_drop", int'(drop_cnt), 0);

    // Arbitration vectors, applied in sequence from rr_ptr=0.
    tbl[0] = '{3'b001, 1'b0, 1'b0, 3'b001, 1'b1,  1};
    tbl[1] = '{3'b111, 1'b0, 1'b0, 3'b010, 1'b1, 11};
    tbl[2] = '{3'b111, 1'b0, 1'b0, 3'b100, 1'b1, 21};
    tbl[3] = '{3'b111, 1'b0, 1'b0, 3'b001, 1'b1,  1};
    tbl[4] = '{3'b101, 1'b0, 1'b0, 3'b100, 1'b1, 21};
    tbl[5] = '{3'b110, 1'b1, 1'b1, 3'b000, 1'b0,  0};
    tbl[6] = '{3'b110, 1'b1, 1'b0, 3'b010, 1'b1, 11};
    tbl[7] = '{3'b011, 1'b0, 1'b1, 3'b001, 1'b1,  1};
    tbl[8] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0,  0};
    tbl[9] = '{3'b101, 1'b0, 1'b0, 3'b100, 1'b1, 21};
    for (int e = 0; e < 10; e++) begin
      for (int i = 0; i < NR; i++) begin
        pv[i] = tbl[e].v[i];
        px[i] = CW'(i * 10 + 1); py[i] = CW'(i * 10 + 2); pp[i] = 3'(i + 1);
      end
      no_tear = tbl[e].nt; visible = tbl[e].vis;
      drive();
      #1 chk("tbl_ready", int'(req_ready), int'(tbl[e].rdy));
      tick();
      chk("tbl_wr_en", int'(wr_en), int'(tbl[e].wr));
      if (tbl[e].wr) begin
        chk("tbl_X", int'(X), tbl[e].x);
        chk("tbl_Y", int'(Y), tbl[e].x + 1);
        chk("tbl_pixel", int'(pixel), (tbl[e].x - 1) / 10 + 1);
      end
    end
    no_tear = 1'b0; visible = 1'b0;
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    drive();
    tick();

    // Single request: one write, one cycle later
    pv[0] = 1'b1; px[0] = CW'(10); py[0] = CW'(20); pp[0] = 3'd5;
    drive();
    #1 chk("single_ready", int'(req_ready), 1);
    tick();
    pv[0] = 1'b0; drive();
    chk("single_wr", int'(wr_en), 1);
    chk("single_X", int'(X), 10);
    chk("single_Y", int'(Y), 20);
    chk("single_pix", int'(pixel), 5);
    tick();
    chk("single_once", int'(wr_en), 0);

    // Out-of-range drop and saturation
    pv[1] = 1'b1; px[1] = CW'(640); py[1] = CW'(0); pp[1] = 3'd3;
    drive();
    #1 chk("drop_ready", int'(req_ready), 2);
    tick();
    chk("drop_wr", int'(wr_en), 0);
    chk("drop_cnt1", int'(drop_cnt), 1);
    for (int k = 0; k < 300; k++) tick();
    pv[1] = 1'b0; drive();
    chk("drop_sat", int'(drop_cnt), 255);
    tick();

    // Clear sweeps
    run_clear(4, 3, 6, 1'b0, 0);
    tick();
    run_clear(4, 2, 5, 1'b1, 0);
    tick();
    run_clear(0, 3, 2, 1'b0, 0);
    tick();

    // Reset in the middle of a clear, then rr_ptr must be back at 0
    run_clear(4, 3, 7, 1'b0, 5);
    chk("abort_post_busy", int'(clear_busy), 0);
    chk("abort_post_drop", int'(drop_cnt), 0);
    for (int i = 0; i < NR; i++) pv[i] = 1'b1;
    drive();
    #1 chk("abort_rr_ptr0", int'(req_ready), 1);
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    drive();

    // Randomized traffic against a reference model
    do_reset();
    width = CW'(20); height = CW'(15);
    ptr = 0; dc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NR; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          px[i] = CW'($urandom_range(0, 23));
          py[i] = CW'($urandom_range(0, 17));
          pp[i] = 3'($urandom_range(0, 7));
        end
      no_tear = 1'($urandom_range(0, 1));
      visible = 1'($urandom_range(0, 1));
      drive();
      g = -1;
      if (!(no_tear && visible)) begin
        best = NR;
        for (int i = 0; i < NR; i++)
          if (pv[i]) begin
            d = (i - ptr + NR) % NR;
            if (d < best) begin best = d; g = i; end
          end
      end
      #1 chk("rand_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
      tick();
      inr = 1'b0;
      if (g >= 0) begin
        inr = (px[g] < 20) && (py[g] < 15);
        ptr = (g + 1) % NR;
        if (!inr && dc < 255) dc++;
      end
      chk("rand_wr_en", int'(wr_en), (g >= 0 && inr) ? 1 : 0);
      if (g >= 0 && inr) begin
        chk("rand_X", int'(X), int'(px[g]));
        chk("rand_Y", int'(Y), int'(py[g]));
        chk("rand_pix", int'(pixel), int'(pp[g]));
      end
      if (g >= 0) pv[g] = 1'b0;
      chk("rand_drop", int'(drop_cnt), dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_write_arbiter.md
Name: vga_fb_write_arbiter

Overview:
- Shares the single framebuffer write port of the VGA controller (X, Y, pixel, wr_en) between NUM_REQ pixel writers.
- Contains a clear sequencer that sweeps the active area with a fill colour, one pixel per clk.
- Optional no-tear mode holds all writes while the display is in its visible region.
- Sits between the drawing clients (CPU bridge, sprite/text engines) and vga; runs in the clk domain.

Parameters:
- NUM_REQ, 3: number of requesters, 1 to 8.
- CW, 10: coordinate width. Must match vga X/Y.

Ports:
- clk  in  1  system clock.
- srst  in  1  reset. Asynchronous, active-high.
- width  in  CW  active width in pixels.
- height  in  CW  active height in pixels.
- no_tear  in  1  1 = stall all writes while visible=1.
- visible  in  1  from vga; already synchronized to clk upstream.
- clear_start  in  1  single-cycle pulse that starts a clear.
- clear_color  in  3  fill colour.
- clear_busy  out  1  high while a clear is in progress.
- req_valid  in  NUM_REQ  per-requester write request.
- req_x  in  NUM_REQ*CW  packed; requester i at [i*CW +: CW].
- req_y  in  NUM_REQ*CW  packed, same layout as req_x.
- req_pixel  in  NUM_REQ*3  packed, 3 bits per requester.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- X  out  CW  to vga.
- Y  out  CW  to vga.
- pixel  out  3  to vga.
- wr_en  out  1  to vga.
- drop_cnt  out  8  saturating count of dropped out-of-range requests.

Behaviour:
- Reset values (asynchronous): X=0, Y=0, pixel=0, wr_en=0, clear_busy=0, drop_cnt=0, rr_ptr=0, state=IDLE.
- req_ready is combinational from the current state, the request inputs and rr_ptr. X, Y, pixel and wr_en are registered.
- Latency: a request accepted in cycle n (req_ready[i]=1) appears on X/Y/pixel/wr_en in cycle n+1.
- wr_en=1 for exactly one cycle per write.
- stall = no_tear & visible.
- States:
  - IDLE (arbitration):
    - If stall=1: req_ready=0 and wr_en=0 next cycle.
    - Otherwise: round-robin grant to the first i with req_valid[i], searching from rr_ptr upward and wrapping. Then rr_ptr <= (i+1) mod NUM_REQ.
    - rr_ptr is unchanged when nothing is granted.
    - A requester holds valid and data stable until it sees ready (valid/ready contract).
    - A granted request with x>=width or y>=height is accepted (ready=1) but dropped: wr_en=0 next cycle and drop_cnt increments, saturating at 255.
    - clear_start=1 has priority over requests that cycle: no grant, req_ready=0. Latch cw<=width, ch<=height, col<=clear_color; cx=cy=0; go to CLEAR.
    - If cw or ch is 0, go to DONE directly with no writes.
    - clear_busy rises in the cycle after clear_start.
  - CLEAR:
    - All req_ready=0.
    - Each non-stalled cycle: emit write (cx, cy, col) and advance cx. At cx=cw-1, wrap cx to 0 and increment cy.
    - The write at (cw-1, ch-1) is the last; go to DONE.
    - Stall cycles freeze cx/cy and emit no write.
    - clear_start during CLEAR is ignored.
    - Changes to width/height/clear_color during CLEAR do not affect it (latched values).
    - Total writes = cw*ch.
  - DONE:
    - One cycle, clear_busy=0, then IDLE.
    - Requests are not granted in DONE.
- Reset asserted mid-clear aborts the clear: clear_busy=0 and the framebuffer is partially cleared (acceptable).
- Counters cx/cy are CW bits. No arithmetic wider than CW+1 bits is needed; comparisons use latched cw-1 and ch-1.

Decomposition:
- Package vga_pkg:
  - CW_DEFAULT.
  - typedef pix_t (logic [2:0]).
  - typedef coord_t (logic [CW-1:0]).
  - enum arb_state_t {IDLE, CLEAR, DONE}.
- One sub-module, rr_arbiter: parameter N; inputs req and ptr, plus en; outputs one-hot gnt and gnt_idx. Purely combinational, reusable.
- The clear sweep stays inline.

Test Plan:
- Single request: width=640, height=480, req0 (10,20,5) held valid → ready[0] in cycle n; X=10, Y=20, pixel=5, wr_en=1 in cycle n+1; one write only.
- Round-robin fairness: NUM_REQ=3, all valid continuously → grants 0,1,2,0,1,2…; each requester gets 1 write per 3 cycles with no gaps.
- Out-of-range drop: req1 (640,0) with width=640 → ready[1]=1, wr_en stays 0, drop_cnt=1; 300 such requests → drop_cnt=255.
- Clear sweep: width=4, height=3, colour 6 → exactly 12 writes in raster order (0,0)…(3,2), clear_busy high for 13 cycles, no req_ready during clear.
- No-tear stall: no_tear=1, visible toggling 4 on / 4 off during clear width=4, height=2 → writes only while visible=0; all 8 writes in order, none duplicated.
- Reset mid-clear: srst asserted at write 5 of 12 → wr_en=0 and clear_busy=0 immediately (asynchronously); after release, IDLE with rr_ptr=0.
